riscv_system_pio_in: RTL and testbench
======================================

Name: riscv_system_pio_in

Overview:
Parametrised input PIO Avalon-MM slave, the successor to the fixed 8-bit read-only switch port. It adds the following for WIDTH inputs such as switches, buttons and external flags:
- two-flop synchroniser
- optional per-bit debounce
- edge capture with write-1-to-clear
- per-bit interrupt mask and a level IRQ to the RISC-V core

Sits on the system interconnect beside the other PIO peripherals.

Parameters:
WIDTH, 8, number of input bits; legal 1..32.
EDGE_TYPE, 0, edge captured: 0 rising, 1 falling, 2 any.
DEBOUNCE_CYCLES, 0, stable cycles required before a bit changes; 0 bypasses debounce.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  2  word register select
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  registered read data
in_port  in  WIDTH  asynchronous external inputs
irq  out  1  level interrupt request

Behaviour:
- Clock and reset: clk is the clock. reset_n is asynchronous, active-low.
- Reset values: all state is 0, i.e. sync1, sync2, deb, prev, counters, irq_mask, edge_capture, readdata. irq is 0.
- Synchroniser: sync1 <= in_port; sync2 <= sync1.
- Debounce, DEBOUNCE_CYCLES=0: deb = sync2, combinational.
- Debounce, DEBOUNCE_CYCLES>0, per bit i, counter width clog2(DEBOUNCE_CYCLES+1):
  - sync2[i]==deb[i]: cnt[i] <= 0.
  - sync2[i]!=deb[i] and cnt[i]==DEBOUNCE_CYCLES-1: deb[i] <= sync2[i], cnt[i] <= 0.
  - otherwise: cnt[i]++.
  - A glitch shorter than DEBOUNCE_CYCLES never reaches deb.
- Edge detect: prev <= deb every cycle.
  - rise = deb & ~prev; fall = ~deb & prev.
  - edge = rise, fall or rise|fall per EDGE_TYPE.
- edge_capture[i] <= (edge_capture[i] & ~clr[i]) | edge[i].
  - clr is writedata[WIDTH-1:0] on a write to address 3, else 0.
  - Simultaneous edge and clear on the same bit: set wins.
- Register map, word addresses:
  - 0: deb, read-only.
  - 1: sync2 (raw, undebounced), read-only.
  - 2: irq_mask, read/write.
  - 3: edge_capture, read / write-1-to-clear.
  - Writes to 0 and 1 are ignored.
- Write strobe: chipselect & ~write_n; sampled on rising clk.
- irq_mask <= writedata[WIDTH-1:0] on a write to 2.
- Reads:
  - readdata <= zero-extended mux(address) every clock, independent of chipselect.
  - Read latency 1 cycle; bits 31:WIDTH always read 0.
  - A read of address 3 in the same cycle as a clear returns the pre-clear value.
- irq = |(edge_capture & irq_mask), combinational from registers; level, held until cleared or masked.
- Latency from in_port change before edge k, DEBOUNCE_CYCLES=0:
  - sync2 valid after edge k+1.
  - edge_capture and irq set after edge k+2.
  - Address-0 readdata reflects the change after edge k+2.
- DEBOUNCE_CYCLES>0 adds exactly DEBOUNCE_CYCLES cycles to this latency.
- Inputs held high through reset produce one rising capture after release. irq_mask is 0 at reset, so there is no IRQ; software clears address 3 before enabling.
- Reset asserted mid-operation clears all state immediately, including pending counts and captures.
- writedata bits above WIDTH are ignored.

Test Plan:
1. Reset, then in_port=8'hA5 held, address 0 → readdata 32'h000000A5 from the third clock after the change; irq stays 0.
2. EDGE_TYPE=0, write 8'h01 to address 2, pulse in_port[0] 0→1 → edge_capture=1 and irq=1 two clocks later. Write 1 to address 3 → irq=0 next cycle.
3. EDGE_TYPE=2, toggle in_port[3] 0→1→0 with captures cleared between toggles → both edges set bit 3. Clear-and-edge in the same cycle → bit 3 stays 1.
4. DEBOUNCE_CYCLES=4, 3-cycle glitch on in_port[1] → address 0 unchanged, no capture. 10-cycle pulse → deb[1] rises exactly 4 cycles after sync2, capture set.
5. WIDTH=32, in_port=32'hDEADBEEF, mask 32'hFFFFFFFF → address 0 reads 32'hDEADBEEF. Assert reset_n mid-run → all outputs 0 asynchronously.
6. Write 32'hFFFFFFFF to address 0 and 1 with WIDTH=8 → no state change; address 2 reads only bits 7:0.

Source files
------------

// File: rtl/riscv_system_pio_in.sv
// rtl/riscv_system_pio_in.sv - parametrised input PIO slave with debounce, edge capture and IRQ
module riscv_system_pio_in #(
    parameter int WIDTH           = 8,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);
    logic [WIDTH-1:0] sync1_q, sync2_q, deb, prev_q;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
    logic [WIDTH-1:0] rise, fall, edge_hit, clr, rd_mux;
    logic [31:0]      readdata_q, readdata_d;
    logic             wr_en;
    logic             unused_wdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= in_port;
            sync2_q <= sync1_q;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_no_deb
            assign deb = sync2_q;
        end else begin : g_deb
            localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [WIDTH-1:0] deb_q;
            logic [CNT_W-1:0] cnt_q [WIDTH];

            // Each bit counts consecutive cycles of disagreement; any agreement restarts it.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    deb_q <= '0;
                    for (int i = 0; i < WIDTH; i++) begin
                        cnt_q[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (sync2_q[i] == deb_q[i]) begin
                            cnt_q[i] <= '0;
                        end else if (cnt_q[i] == CNT_LAST) begin
                            deb_q[i] <= sync2_q[i];
                            cnt_q[i] <= '0;
                        end else begin
                            cnt_q[i] <= cnt_q[i] + 1'b1;
                        end
                    end
                end
            end

            assign deb = deb_q;
        end
    endgenerate

    always_comb begin
        rise = deb & ~prev_q;
        fall = ~deb & prev_q;
        if (EDGE_TYPE == 0) begin
            edge_hit = rise;
        end else if (EDGE_TYPE == 1) begin
            edge_hit = fall;
        end else begin
            edge_hit = rise | fall;
        end
    end

    assign wr_en        = chipselect & ~write_n;
    assign unused_wdata = ^writedata;

    always_comb begin
        clr            = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
        // OR-ing the new edge after the clear makes a coincident edge win.
        edge_capture_d = (edge_capture_q & ~clr) | edge_hit;
        irq_mask_d     = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : irq_mask_q;
    end

    always_comb begin
        case (address)
            2'd0:    rd_mux = deb;
            2'd1:    rd_mux = sync2_q;
            2'd2:    rd_mux = irq_mask_q;
            default: rd_mux = edge_capture_q;
        endcase
        readdata_d              = '0;
        readdata_d[WIDTH-1:0]   = rd_mux;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q         <= '0;
            irq_mask_q     <= '0;
            edge_capture_q <= '0;
            readdata_q     <= '0;
        end else begin
            prev_q         <= deb;
            irq_mask_q     <= irq_mask_d;
            edge_capture_q <= edge_capture_d;
            readdata_q     <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edge_capture_q & irq_mask_q);

endmodule

// File: tb/tb_riscv_system_pio_in.sv
// tb/tb_riscv_system_pio_in.sv - vector table, corner sequences and random run against a window model
module tb_riscv_system_pio_in;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [7:0]  in0 = 8'd0;
    logic [7:0]  in1 = 8'd0;
    logic [31:0] in2 = 32'd0;
    logic [31:0] rd0, rd1, rd2;
    logic        irq0, irq1, irq2;
    logic        chk_en = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    riscv_system_pio_in #(.WIDTH(8), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(0)) u0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd0), .in_port(in0), .irq(irq0));

    riscv_system_pio_in #(.WIDTH(8), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(4)) u1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd1), .in_port(in1), .irq(irq1));

    riscv_system_pio_in #(.WIDTH(32), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(0)) u2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd2), .in_port(in2), .irq(irq2));

    // Reference: debounced bit flips once the last D sampled raw values all disagree with it.
    typedef struct packed {
        logic [31:0]       s1, s2, deb, prev, mask, cap, rd;
        logic [3:0][31:0]  hist;
    } mdl_t;

    function automatic mdl_t mstep(input mdl_t m, input logic [31:0] inp, input int w,
                                   input int et, input int d, input logic [1:0] a,
                                   input logic cs, input logic wn, input logic [31:0] wd);
        mdl_t        n;
        logic [31:0] wm, dn, rise, fall, edg, clr;
        bit          all_diff;
        wm   = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        dn   = (d == 0) ? m.s2 : m.deb;
        rise = dn & ~m.prev;
        fall = ~dn & m.prev;
        edg  = (et == 0) ? rise : (et == 1) ? fall : (rise | fall);
        n    = m;
        case (a)
            2'd0:    n.rd = dn;
            2'd1:    n.rd = m.s2;
            2'd2:    n.rd = m.mask;
            default: n.rd = m.cap;
        endcase
        clr   = (cs && !wn && a == 2'd3) ? (wd & wm) : 32'd0;
        n.cap = (m.cap & ~clr) | edg;
        if (cs && !wn && a == 2'd2) n.mask = wd & wm;
        n.prev = dn;
        n.s1   = inp & wm;
        n.s2   = m.s1;
        if (d > 0) begin
            for (int j = 3; j > 0; j--) n.hist[j] = m.hist[j-1];
            n.hist[0] = m.s2;
            for (int i = 0; i < w; i++) begin
                all_diff = 1'b1;
                for (int j = 0; j < d; j++) begin
                    if (n.hist[j][i] == m.deb[i]) all_diff = 1'b0;
                end
                if (all_diff) n.deb[i] = ~m.deb[i];
            end
        end
        return n;
    endfunction

    mdl_t m0, m1, m2;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m0 <= '0;
            m1 <= '0;
            m2 <= '0;
        end else begin
            m0 <= mstep(m0, {24'd0, in0}, 8, 0, 0, address, chipselect, write_n, writedata);
            m1 <= mstep(m1, {24'd0, in1}, 8, 2, 4, address, chipselect, write_n, writedata);
            m2 <= mstep(m2, in2, 32, 1, 0, address, chipselect, write_n, writedata);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("mdl_rd0", rd0, m0.rd);
            check("mdl_rd1", rd1, m1.rd);
            check("mdl_rd2", rd2, m2.rd);
            check("mdl_irq0", {31'd0, irq0}, {31'd0, |(m0.cap & m0.mask)});
            check("mdl_irq1", {31'd0, irq1}, {31'd0, |(m1.cap & m1.mask)});
            check("mdl_irq2", {31'd0, irq2}, {31'd0, |(m2.cap & m2.mask)});
        end
    end

    task automatic cyc(input logic [1:0] a, input logic cs, input logic wn, input logic [31:0] wd);
        address    = a;
        chipselect = cs;
        write_n    = wn;
        writedata  = wd;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(2'd0, 1'b0, 1'b1, 32'd0);
    endtask

    typedef struct {
        logic [1:0]  a;
        logic        cs;
        logic        wn;
        logic [31:0] wd;
        logic [7:0]  in;
        logic [31:0] rd;
        logic        irq;
    } vec_t;

    localparam int NV = 23;
    vec_t tbl [NV];

    initial begin
        int t0, t1;
        bit seen;

        tbl[0]  = '{2'd0, 1'b0, 1'b1, 32'h0,        8'hA5, 32'h0,  1'b0};
        tbl[1]  = '{2'd0, 1'b0, 1'b1, 32'h0,        8'hA5, 32'h0,  1'b0};
        tbl[2]  = '{2'd0, 1'b0, 1'b1, 32'h0,        8'hA5, 32'hA5, 1'b0};
        tbl[3]  = '{2'd3, 1'b0, 1'b1, 32'h0,        8'hA5, 32'hA5, 1'b0};
        tbl[4]  = '{2'd2, 1'b1, 1'b0, 32'hFFFFFF01, 8'hA5, 32'h0,  1'b1};
        tbl[5]  = '{2'd2, 1'b0, 1'b1, 32'h0,        8'hA5, 32'h01, 1'b1};
        tbl[6]  = '{2'd3, 1'b1, 1'b0, 32'hFFFFFFFF, 8'hA5, 32'hA5, 1'b0};
        tbl[7]  = '{2'd3, 1'b0, 1'b1, 32'h0,        8'hA5, 32'h0,  1'b0};
        tbl[8]  = '{2'd0, 1'b1, 1'b0, 32'hFFFFFFFF, 8'hA5, 32'hA5, 1'b0};
        tbl[9]  = '{2'd1, 1'b1, 1'b0, 32'hFFFFFFFF, 8'hA5, 32'hA5, 1'b0};
        tbl[10] = '{2'd2, 1'b0, 1'b1, 32'h0,        8'hA5, 32'h01, 1'b0};
        tbl[11] = '{2'd0, 1'b0, 1'b1, 32'h0,        8'hA4, 32'hA5, 1'b0};
        tbl[12] = '{2'd0, 1'b0, 1'b1, 32'h0,        8'hA5, 32'hA5, 1'b0};
        tbl[13] = '{2'd0, 1'b0, 1'b1, 32'h0,        8'hA5, 32'hA4, 1'b0};
        tbl[14] = '{2'd3, 1'b0, 1'b1, 32'h0,        8'hA5, 32'h0,  1'b1};
        tbl[15] = '{2'd3, 1'b0, 1'b1, 32'h0,        8'hA5, 32'h01, 1'b1};
        tbl[16] = '{2'd3, 1'b1, 1'b0, 32'h0,        8'hA5, 32'h01, 1'b1};
        tbl[17] = '{2'd2, 1'b1, 1'b0, 32'h0,        8'hA5, 32'h01, 1'b0};
        tbl[18] = '{2'd3, 1'b0, 1'b1, 32'h0,        8'hA5, 32'h01, 1'b0};
        tbl[19] = '{2'd3, 1'b1, 1'b0, 32'h1,        8'hA5, 32'h01, 1'b0};
        tbl[20] = '{2'd3, 1'b0, 1'b1, 32'h0,        8'hA5, 32'h0,  1'b0};
        tbl[21] = '{2'd2, 1'b0, 1'b0, 32'hFF,       8'hA5, 32'h0,  1'b0};
        tbl[22] = '{2'd2, 1'b0, 1'b1, 32'h0,        8'hA5, 32'h0,  1'b0};

        repeat (3) @(negedge clk);
        check("reset_rd0", rd0, 32'd0);
        check("reset_rd2", rd2, 32'd0);
        check("reset_irq", {29'd0, irq0, irq1, irq2}, 32'd0);
        reset_n = 1'b1;
        chk_en  = 1'b1;
        idle(3);

        for (int i = 0; i < NV; i++) begin
            in0 = tbl[i].in;
            cyc(tbl[i].a, tbl[i].cs, tbl[i].wn, tbl[i].wd);
            check($sformatf("tbl%0d_rd", i), rd0, tbl[i].rd);
            check($sformatf("tbl%0d_irq", i), {31'd0, irq0}, {31'd0, tbl[i].irq});
        end

        // Debounced instance: a 3-cycle glitch must never reach the filtered value.
        cyc(2'd3, 1'b1, 1'b0, 32'hFFFF_FFFF);
        seen = 1'b0;
        for (int c = 0; c < 14; c++) begin
            in1 = (c < 3) ? 8'h02 : 8'h00;
            cyc(2'd0, 1'b0, 1'b1, 32'd0);
            if (rd1[1]) seen = 1'b1;
        end
        check("glitch_deb", {31'd0, seen}, 32'd0);
        cyc(2'd3, 1'b0, 1'b1, 32'd0);
        check("glitch_cap", rd1, 32'd0);

        t1 = -1;
        for (int c = 0; c < 24; c++) begin
            in1 = (c < 10) ? 8'h02 : 8'h00;
            cyc(2'd1, 1'b0, 1'b1, 32'd0);
            if (rd1[1] && t1 < 0) t1 = c;
        end
        t0 = -1;
        for (int c = 0; c < 24; c++) begin
            in1 = (c < 10) ? 8'h02 : 8'h00;
            cyc(2'd0, 1'b0, 1'b1, 32'd0);
            if (rd1[1] && t0 < 0) t0 = c;
        end
        check("sync2_latency", 32'(t1), 32'd2);
        check("deb_latency", 32'(t0), 32'd6);
        cyc(2'd3, 1'b0, 1'b1, 32'd0);
        check("pulse_cap", rd1, 32'h02);

        // Any-edge capture on bit 3, cleared between toggles.
        cyc(2'd3, 1'b1, 1'b0, 32'hFFFF_FFFF);
        in1 = 8'h08;
        idle(12);
        cyc(2'd3, 1'b0, 1'b1, 32'd0);
        check("any_rise", rd1, 32'h08);
        cyc(2'd3, 1'b1, 1'b0, 32'h08);
        in1 = 8'h00;
        idle(12);
        cyc(2'd3, 1'b0, 1'b1, 32'd0);
        check("any_fall", rd1, 32'h08);

        // Edge lands at k+2+DEBOUNCE_CYCLES; the clear is timed onto that same edge.
        in1 = 8'h08;
        cyc(2'd3, 1'b1, 1'b0, 32'hFFFF_FFFF);
        idle(5);
        cyc(2'd3, 1'b1, 1'b0, 32'h08);
        check("clr_edge_pre", rd1, 32'd0);
        cyc(2'd3, 1'b0, 1'b1, 32'd0);
        check("clr_edge_set_wins", rd1, 32'h08);

        // 32-bit falling-edge instance, then asynchronous reset mid-cycle.
        cyc(2'd2, 1'b1, 1'b0, 32'hFFFF_FFFF);
        cyc(2'd3, 1'b1, 1'b0, 32'hFFFF_FFFF);
        in2 = 32'hDEAD_BEEF;
        cyc(2'd0, 1'b0, 1'b1, 32'd0);
        cyc(2'd0, 1'b0, 1'b1, 32'd0);
        check("w32_pre", rd2, 32'd0);
        cyc(2'd0, 1'b0, 1'b1, 32'd0);
        check("w32_deb", rd2, 32'hDEAD_BEEF);
        idle(2);
        check("w32_rise_noirq", {31'd0, irq2}, 32'd0);
        in2 = 32'd0;
        idle(4);
        cyc(2'd3, 1'b0, 1'b1, 32'd0);
        check("w32_fall_cap", rd2, 32'hDEAD_BEEF);
        check("w32_irq", {31'd0, irq2}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rd", rd0 | rd1 | rd2, 32'd0);
        check("async_irq", {29'd0, irq0, irq1, irq2}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // in0 held at A5 through reset: one rising capture, masked.
        idle(4);
        cyc(2'd3, 1'b0, 1'b1, 32'd0);
        check("held_high_cap", rd0, 32'hA5);
        check("held_high_noirq", {31'd0, irq0}, 32'd0);

        for (int c = 0; c < 800; c++) begin
            in0 = 8'($urandom);
            if ($urandom_range(0, 7) == 0) in1 = 8'($urandom);
            if ($urandom_range(0, 1) == 0) in2 = $urandom;
            cyc(2'($urandom_range(0, 3)), 1'($urandom), ($urandom_range(0, 3) != 0), $urandom);
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
